// File: rtl/conv_pkg.sv
// Shared constants, counter widths and FSM state type for the 128x32 streaming convolver.
package conv_pkg;

    localparam int X_LEN  = 128;
    localparam int F_LEN  = 32;
    localparam int Y_LEN  = 97;
    localparam int IN_W   = 8;
    localparam int OUT_W  = 21;
    localparam int PROD_W = 2 * IN_W;

    localparam int XCNT_W = $clog2(X_LEN + 1);
    localparam int FCNT_W = $clog2(F_LEN + 1);
    localparam int YCNT_W = $clog2(Y_LEN);
    localparam int XA_W   = $clog2(X_LEN);
    localparam int FA_W   = $clog2(F_LEN);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } conv_state_e;

endpackage

// File: rtl/conv_mem.sv
// Single-write, single-read memory with a registered read port (1-cycle read latency).
// No flow control: the writer and reader own the address sequencing.
module conv_mem #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/conv_128_32_opt.sv
// Streaming 1-D convolution: 32 MAC cycles + read (+ multiplier stage with CONV_MULT_PIPE_EN) + 1 per output.
// Inputs stall (ready low) outside LOAD; each result is held until m_ready_y, with no output buffering.
module conv_128_32_opt
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  s_data_in_x,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    input  logic [IN_W-1:0]  s_data_in_f,
    input  logic             s_valid_f,
    output logic             s_ready_f,
    output logic [OUT_W-1:0] m_data_out_y,
    output logic             m_valid_y,
    input  logic             m_ready_y
);

    conv_state_e              state_q, state_d;
    logic [XCNT_W-1:0]        x_cnt_q, x_cnt_d;
    logic [FCNT_W-1:0]        f_cnt_q, f_cnt_d;
    logic [YCNT_W-1:0]        i_q, i_d;
    logic [FCNT_W-1:0]        j_q, j_d;
    logic                     rdy_x_q, rdy_x_d;
    logic                     rdy_f_q, rdy_f_d;
    logic signed [OUT_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]         y_q, y_d;
    logic                     vld_q, vld_d;
    logic                     rd_vld_q, rd_last_q;

    logic                     x_we, f_we, iss;
    logic [XA_W-1:0]          x_raddr;
    logic [IN_W-1:0]          x_rdata, f_rdata;
    logic signed [PROD_W-1:0] prod, acc_in;
    logic signed [OUT_W-1:0]  acc_sum;
    logic                     acc_vld, acc_last;

    assign x_we    = s_valid_x && rdy_x_q;
    assign f_we    = s_valid_f && rdy_f_q;
    assign iss     = (state_q == ST_COMPUTE) && (j_q < FCNT_W'(F_LEN));
    assign x_raddr = XA_W'(i_q) + XA_W'(j_q[FA_W-1:0]);

    conv_mem #(.DEPTH(X_LEN), .WIDTH(IN_W), .AW(XA_W)) u_xmem (
        .clk_i   (clk),
        .we_i    (x_we),
        .waddr_i (x_cnt_q[XA_W-1:0]),
        .wdata_i (s_data_in_x),
        .raddr_i (x_raddr),
        .rdata_o (x_rdata)
    );

    conv_mem #(.DEPTH(F_LEN), .WIDTH(IN_W), .AW(FA_W)) u_fmem (
        .clk_i   (clk),
        .we_i    (f_we),
        .waddr_i (f_cnt_q[FA_W-1:0]),
        .wdata_i (s_data_in_f),
        .raddr_i (j_q[FA_W-1:0]),
        .rdata_o (f_rdata)
    );

    assign prod = $signed(x_rdata) * $signed(f_rdata);

`ifdef CONV_MULT_PIPE_EN
    logic signed [PROD_W-1:0] prod_q;
    logic                     mul_vld_q, mul_last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q     <= '0;
            mul_vld_q  <= 1'b0;
            mul_last_q <= 1'b0;
        end else begin
            prod_q     <= prod;
            mul_vld_q  <= rd_vld_q;
            mul_last_q <= rd_last_q;
        end
    end

    assign acc_in   = prod_q;
    assign acc_vld  = mul_vld_q;
    assign acc_last = mul_last_q;
`else
    assign acc_in   = prod;
    assign acc_vld  = rd_vld_q;
    assign acc_last = rd_last_q;
`endif

    assign acc_sum = acc_q + {{(OUT_W-PROD_W){acc_in[PROD_W-1]}}, acc_in};

    always_comb begin
        state_d = state_q;
        x_cnt_d = x_cnt_q;
        f_cnt_d = f_cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        y_d     = y_q;
        vld_d   = vld_q;
        case (state_q)
            ST_LOAD: begin
                if (x_we) x_cnt_d = x_cnt_q + XCNT_W'(1);
                if (f_we) f_cnt_d = f_cnt_q + FCNT_W'(1);
                if (x_cnt_q == XCNT_W'(X_LEN) && f_cnt_q == FCNT_W'(F_LEN)) begin
                    state_d = ST_COMPUTE;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            ST_COMPUTE: begin
                if (iss) j_d = j_q + FCNT_W'(1);
                if (acc_vld) begin
                    acc_d = acc_sum;
                    if (acc_last) begin
                        y_d     = acc_sum;
                        vld_d   = 1'b1;
                        state_d = ST_OUTPUT;
                    end
                end
            end
            ST_OUTPUT: begin
                // Accumulator is cleared here so every output starts from zero.
                if (m_ready_y) begin
                    vld_d = 1'b0;
                    j_d   = '0;
                    acc_d = '0;
                    if (i_q == YCNT_W'(Y_LEN - 1)) begin
                        state_d = ST_LOAD;
                        i_d     = '0;
                        x_cnt_d = '0;
                        f_cnt_d = '0;
                    end else begin
                        state_d = ST_COMPUTE;
                        i_d     = i_q + YCNT_W'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
        // Readies are registered from next state so they are low during and right after reset.
        rdy_x_d = (state_d == ST_LOAD) && (x_cnt_d != XCNT_W'(X_LEN));
        rdy_f_d = (state_d == ST_LOAD) && (f_cnt_d != FCNT_W'(F_LEN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            x_cnt_q   <= '0;
            f_cnt_q   <= '0;
            i_q       <= '0;
            j_q       <= '0;
            rdy_x_q   <= 1'b0;
            rdy_f_q   <= 1'b0;
            acc_q     <= '0;
            y_q       <= '0;
            vld_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_cnt_q   <= x_cnt_d;
            f_cnt_q   <= f_cnt_d;
            i_q       <= i_d;
            j_q       <= j_d;
            rdy_x_q   <= rdy_x_d;
            rdy_f_q   <= rdy_f_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            vld_q     <= vld_d;
            rd_vld_q  <= iss;
            rd_last_q <= iss && (j_q == FCNT_W'(F_LEN - 1));
        end
    end

    assign s_ready_x    = rdy_x_q;
    assign s_ready_f    = rdy_f_q;
    assign m_valid_y    = vld_q;
    assign m_data_out_y = y_q;

endmodule

// File: tb/tb_conv_128_32_opt.sv
// Directed bench for conv_128_32_opt with a reference-sum scoreboard.
module tb_conv_128_32_opt;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data_in_x, s_data_in_f;
    logic        s_valid_x, s_valid_f, s_ready_x, s_ready_f;
    logic [20:0] m_data_out_y;
    logic        m_valid_y, m_ready_y;

    int vectors = 0;
    int errs    = 0;
    int xv [128];
    int fv [32];
    int sb [$];

    always #5 clk = ~clk;

    conv_128_32_opt dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready_x),
        .s_data_in_f  (s_data_in_f),
        .s_valid_f    (s_valid_f),
        .s_ready_f    (s_ready_f),
        .m_data_out_y (m_data_out_y),
        .m_valid_y    (m_valid_y),
        .m_ready_y    (m_ready_y)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_vecs(input int mode);
        for (int k = 0; k < 128; k++) begin
            case (mode)
                0: xv[k] = k - 128;
                1: xv[k] = k;
                default: xv[k] = -128;
            endcase
        end
        for (int j = 0; j < 32; j++) begin
            case (mode)
                0: fv[j] = j - 64;
                1: fv[j] = j - 32;
                2: fv[j] = -128;
                default: fv[j] = 127;
            endcase
        end
    endtask

    task automatic load_set(input bit rnd);
        for (int i = 0; i < 97; i++) begin
            int s = 0;
            for (int j = 0; j < 32; j++) s += xv[i+j] * fv[j];
            sb.push_back(s);
        end
        fork
            begin
                int k = 0;
                int t = 0;
                bit xfer;
                while (k < 128 && t < 5000) begin
                    s_data_in_x = 8'(xv[k]);
                    s_valid_x   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(negedge clk);
                    xfer = s_valid_x && s_ready_x;
                    @(posedge clk); #1;
                    if (xfer) k++;
                    t++;
                end
                s_valid_x = 1'b0;
                check("x_loaded", k, 128);
            end
            begin
                int k = 0;
                int t = 0;
                bit xfer;
                while (k < 32 && t < 5000) begin
                    s_data_in_f = 8'(fv[k]);
                    s_valid_f   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(negedge clk);
                    xfer = s_valid_f && s_ready_f;
                    @(posedge clk); #1;
                    if (xfer) k++;
                    t++;
                end
                s_valid_f = 1'b0;
                check("f_loaded", k, 32);
            end
        join
    endtask

    task automatic collect(input int n, input bit rnd);
        int got = 0;
        int t = 0;
        int rdy_bad = 0;
        logic signed [31:0] exp;
        while (got < n && t < 20000) begin
            m_ready_y = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_ready_x || s_ready_f) rdy_bad++;
            if (m_valid_y && m_ready_y) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 'x;
                check("y", $signed(m_data_out_y), exp);
                got++;
            end
            @(posedge clk); #1;
            t++;
        end
        m_ready_y = 1'b0;
        check("y_count", got, n);
        check("in_ready_low_while_busy", rdy_bad, 0);
    endtask

    initial begin
        int cnt;
        int bad;
        reset = 1'b1;
        s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
        s_data_in_x = '0; s_data_in_f = '0;
        repeat (3) @(negedge clk);
        check("rst_ready_x", s_ready_x, 0);
        check("rst_ready_f", s_ready_f, 0);
        check("rst_valid_y", m_valid_y, 0);
        check("rst_data_y", m_data_out_y, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_x_before_edge", s_ready_x, 0);
        @(negedge clk);
        check("ready_x_after_rst", s_ready_x, 1);
        check("ready_f_after_rst", s_ready_f, 1);
        @(posedge clk); #1;

        // Runs 1 and 2 back to back with random handshakes.
        set_vecs(0); load_set(1'b1); collect(97, 1'b1);
        set_vecs(1); load_set(1'b1); collect(97, 1'b1);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (m_valid_y !== 1'b0) cnt++;
            @(posedge clk); #1;
        end
        check("idle_valid_after_set", cnt, 0);

        // Extreme positive, with a 50-cycle stall on the first output.
        set_vecs(2); load_set(1'b0);
        cnt = 0;
        @(negedge clk);
        while (!m_valid_y && cnt < 2000) begin
            @(posedge clk); #1;
            @(negedge clk);
            cnt++;
        end
        check("hold_valid_seen", m_valid_y, 1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (m_valid_y !== 1'b1 || $signed(m_data_out_y) !== sb[0] || s_ready_x || s_ready_f) bad++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        check("hold_bad_cycles", bad, 0);
        check("hold_data", $signed(m_data_out_y), 524288);
        @(posedge clk); #1;
        collect(97, 1'b0);

        // Extreme negative.
        set_vecs(3); load_set(1'b1); collect(97, 1'b1);

        // Reset with an output pending discards it.
        set_vecs(1); load_set(1'b0);
        cnt = 0;
        @(negedge clk);
        while (!m_valid_y && cnt < 2000) begin
            @(posedge clk); #1;
            @(negedge clk);
            cnt++;
        end
        check("pend_valid_seen", m_valid_y, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("pend_rst_valid", m_valid_y, 0);
        check("pend_rst_data", m_data_out_y, 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset after 60 x samples, then a fresh run 1.
        set_vecs(0);
        for (int c = 0; c < 60; c++) begin
            s_data_in_x = 8'(xv[c]);
            s_valid_x   = 1'b1;
            s_data_in_f = 8'(fv[c % 32]);
            s_valid_f   = (c < 32);
            @(posedge clk); #1;
        end
        s_valid_x = 1'b0; s_valid_f = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midload_rst_ready_x", s_ready_x, 0);
        check("midload_rst_ready_f", s_ready_f, 0);
        check("midload_rst_valid", m_valid_y, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        load_set(1'b1); collect(97, 1'b1);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
